cond_exec_unit: RTL and testbench

- Sequential successor to the combinational condition checker in the microProcessor datapath.
- Holds banked NZCV flag registers (one bank per execution context) and evaluates the 4-bit ARM condition field against the selected bank.
- Gates PCSrc, RegWrite and MemWrite, with an optional registered output stage for the pipelined core.
- Adds stall, flush and a saturating squashed-instruction counter.

---
 rtl/cond_exec_unit.sv | 199 +++++++++++++++++++
 tb/tb_cond_exec_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_unit.sv
// -----------------------------------------------------------------------------
// cond_exec_unit
//
// Conditional-execution stage for the pipelined core. Holds one NZCV flag bank
// per execution context and evaluates the 4-bit ARM condition field against
// the selected bank. The result gates PCSrc, RegWrite and MemWrite. A
// saturating counter records instructions squashed by a failed condition.
//
// Parameters
//   NUM_CTX  number of banked NZCV flag sets (>= 1)
//   CTX_W    width of ctx_sel, 2**CTX_W >= NUM_CTX
//   PIPE     1 = gated outputs registered (latency 1), 0 = combinational
//   CNT_W    width of the squash counter
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   en            stage enable, 0 = stall
//   flush         squash the current instruction
//   valid_i       instruction present
//   cond          condition field, instruction bits [31:28]
//   alu_flags     {N,Z,C,V} from the ALU
//   flag_w        [1] writes N,Z  [0] writes C,V
//   pcs_i         ungated PCSrc
//   reg_w_i       ungated RegWrite
//   mem_w_i       ungated MemWrite
//   no_write_i    compare-type op, suppresses RegWrite
//   ctx_sel       flag bank select (out-of-range values use bank 0)
//   cond_ex_o     combinational condition result for the current instruction
//   flags_o       {N,Z,C,V} of the selected bank
//   valid_o       instruction valid at the output
//   pcsrc_o       gated PCSrc
//   reg_write_o   gated RegWrite
//   mem_write_o   gated MemWrite
//   squash_cnt_o  count of condition-failed instructions, saturating
// -----------------------------------------------------------------------------
module cond_exec_unit #(
   parameter int NUM_CTX = 2,
   parameter int CTX_W   = 1,
   parameter int PIPE    = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             valid_i,
   input  logic [3:0]       cond,
   input  logic [3:0]       alu_flags,
   input  logic [1:0]       flag_w,
   input  logic             pcs_i,
   input  logic             reg_w_i,
   input  logic             mem_w_i,
   input  logic             no_write_i,
   input  logic [CTX_W-1:0] ctx_sel,
   output logic             cond_ex_o,
   output logic [3:0]       flags_o,
   output logic             valid_o,
   output logic             pcsrc_o,
   output logic             reg_write_o,
   output logic             mem_write_o,
   output logic [CNT_W-1:0] squash_cnt_o
);

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   logic [3:0]         bank [NUM_CTX];
   logic [NUM_CTX-1:0] bank_sel;
   logic [3:0]         cur_flags;
   logic               flag_n, flag_z, flag_c, flag_v;
   logic               live;     // instruction accepted this cycle
   logic               ok;       // accepted and condition passed
   logic               squash;   // accepted and condition failed
   logic               pcs_g, rw_g, mw_g;
   logic [CNT_W-1:0]   squash_cnt;

   // One-hot bank select; any ctx_sel without a matching bank falls back to
   // bank 0 so reads and writes always agree on the target.
   // NOTE: every always_comb output gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      bank_sel    = '0;
      bank_sel[0] = 1'b1;
      for (int i = 1; i < NUM_CTX; i++) begin
         if (ctx_sel == CTX_W'(i)) begin
            bank_sel    = '0;
            bank_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      cur_flags = '0;
      for (int i = 0; i < NUM_CTX; i++) begin
         if (bank_sel[i]) cur_flags = bank[i];
      end
   end

   assign {flag_n, flag_z, flag_c, flag_v} = cur_flags;

   // Condition decode against registered flags only; a flag write in this
   // cycle becomes visible to the next instruction.
   always_comb begin
      case (cond_e'(cond))
         COND_EQ: cond_ex_o = flag_z;
         COND_NE: cond_ex_o = ~flag_z;
         COND_CS: cond_ex_o = flag_c;
         COND_CC: cond_ex_o = ~flag_c;
         COND_MI: cond_ex_o = flag_n;
         COND_PL: cond_ex_o = ~flag_n;
         COND_VS: cond_ex_o = flag_v;
         COND_VC: cond_ex_o = ~flag_v;
         COND_HI: cond_ex_o = flag_c & ~flag_z;
         COND_LS: cond_ex_o = ~flag_c | flag_z;
         COND_GE: cond_ex_o = (flag_n == flag_v);
         COND_LT: cond_ex_o = (flag_n != flag_v);
         COND_GT: cond_ex_o = ~flag_z & (flag_n == flag_v);
         COND_LE: cond_ex_o = flag_z | (flag_n != flag_v);
         COND_AL: cond_ex_o = 1'b1;
         default: cond_ex_o = 1'b0;   // NV
      endcase
   end

   assign live   = valid_i & en & ~flush;
   assign ok     = live & cond_ex_o;
   assign squash = live & ~cond_ex_o;

   assign pcs_g = ok & pcs_i;
   assign rw_g  = ok & reg_w_i & ~no_write_i;
   assign mw_g  = ok & mem_w_i;

   // NOTE: the flag banks are architectural state the condition logic reads
   // right after reset, so every bank is cleared rather than left unreset
   // like a plain storage array.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // always_ff sees the pre-edge values of all other registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CTX; i++) bank[i] <= '0;
      end else if (ok) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            if (bank_sel[i]) begin
               if (flag_w[1]) bank[i][3:2] <= alu_flags[3:2];
               if (flag_w[0]) bank[i][1:0] <= alu_flags[1:0];
            end
         end
      end
   end

   // Saturating squash counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         squash_cnt <= '0;
      end else if (squash && (squash_cnt != '1)) begin
         squash_cnt <= squash_cnt + CNT_W'(1);
      end
   end

   assign flags_o      = cur_flags;
   assign squash_cnt_o = squash_cnt;

   generate
      if (PIPE != 0) begin : g_pipe
         logic valid_q, pcs_q, rw_q, mw_q;

         // A stall freezes the whole output stage; flush only matters when
         // the stage is advancing.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_q <= 1'b0;
               pcs_q   <= 1'b0;
               rw_q    <= 1'b0;
               mw_q    <= 1'b0;
            end else if (en) begin
               valid_q <= valid_i & ~flush;
               pcs_q   <= pcs_g;
               rw_q    <= rw_g;
               mw_q    <= mw_g;
            end
         end

         assign valid_o     = valid_q;
         assign pcsrc_o     = pcs_q;
         assign reg_write_o = rw_q;
         assign mem_write_o = mw_q;
      end else begin : g_comb
         assign valid_o     = live;
         assign pcsrc_o     = pcs_g;
         assign reg_write_o = rw_g;
         assign mem_write_o = mw_g;
      end
   endgenerate

endmodule

// File: tb/tb_cond_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_cond_exec_unit
//
// Two instances share one stimulus stream: dut_a registers its outputs with an
// 8-bit squash counter, dut_b is combinational with a 2-bit counter. Both have
// three banks behind a 2-bit select so select value 3 exercises the fallback
// to bank 0. The driver pushes the expected outputs for every cycle into a
// queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_cond_exec_unit;

   localparam int NCTX = 3;
   localparam int CW   = 2;

   typedef struct {
      logic       rst_n, en, flush, valid;
      logic [3:0] cond, alu;
      logic [1:0] fw;
      logic       pcs, rw, mw, nw;
      logic [1:0] ctx;
   } stim_t;

   typedef struct {
      logic       cond_ex;
      logic [3:0] flags;
      logic       a_valid, a_pcs, a_rw, a_mw;
      logic [7:0] a_cnt;
      logic       b_valid, b_pcs, b_rw, b_mw;
      logic [1:0] b_cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n, en, flush, valid_i;
   logic [3:0]    cond, alu_flags;
   logic [1:0]    flag_w;
   logic          pcs_i, reg_w_i, mem_w_i, no_write_i;
   logic [CW-1:0] ctx_sel;

   logic       a_cond_ex, a_valid, a_pcs, a_rw, a_mw;
   logic [3:0] a_flags;
   logic [7:0] a_cnt;
   logic       b_cond_ex, b_valid, b_pcs, b_rw, b_mw;
   logic [3:0] b_flags;
   logic [1:0] b_cnt;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];

   // reference model state (value after the most recent modelled edge)
   logic [3:0] m_bank [NCTX];
   logic       m_valid, m_pcs, m_rw, m_mw;
   int         m_cnt_a, m_cnt_b;

   always #5 clk = ~clk;

   cond_exec_unit #(.NUM_CTX(NCTX), .CTX_W(CW), .PIPE(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
      .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs_i(pcs_i),
      .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .no_write_i(no_write_i),
      .ctx_sel(ctx_sel), .cond_ex_o(a_cond_ex), .flags_o(a_flags),
      .valid_o(a_valid), .pcsrc_o(a_pcs), .reg_write_o(a_rw),
      .mem_write_o(a_mw), .squash_cnt_o(a_cnt)
   );

   cond_exec_unit #(.NUM_CTX(NCTX), .CTX_W(CW), .PIPE(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .valid_i(valid_i),
      .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs_i(pcs_i),
      .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .no_write_i(no_write_i),
      .ctx_sel(ctx_sel), .cond_ex_o(b_cond_ex), .flags_o(b_flags),
      .valid_o(b_valid), .pcsrc_o(b_pcs), .reg_write_o(b_rw),
      .mem_write_o(b_mw), .squash_cnt_o(b_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // ARM rule: cond[3:1] picks a base test, cond[0] inverts it (AL/NV pair too).
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1'b1; s.en = 1'b1; s.flush = 1'b0; s.valid = 1'b0;
      s.cond = 4'hE; s.alu = 4'h0; s.fw = 2'b00;
      s.pcs = 1'b0; s.rw = 1'b0; s.mw = 1'b0; s.nw = 1'b0; s.ctx = 2'd0;
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCTX; i++) m_bank[i] = 4'h0;
      m_valid = 1'b0; m_pcs = 1'b0; m_rw = 1'b0; m_mw = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
   endtask

   // Apply one cycle of stimulus, queue what the outputs must show before the
   // next rising edge, then advance the model across that edge.
   task automatic drive(input stim_t s);
      exp_t       e;
      int         idx;
      logic [3:0] f;
      logic       ce, live, ok;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; en = s.en; flush = s.flush; valid_i = s.valid;
      cond = s.cond; alu_flags = s.alu; flag_w = s.fw;
      pcs_i = s.pcs; reg_w_i = s.rw; mem_w_i = s.mw; no_write_i = s.nw;
      ctx_sel = s.ctx;

      idx  = (int'(s.ctx) < NCTX) ? int'(s.ctx) : 0;
      f    = m_bank[idx];
      ce   = cond_holds(s.cond, f);
      live = s.valid && s.en && !s.flush;
      ok   = live && ce;

      e.cond_ex = ce;
      e.flags   = f;
      e.a_valid = m_valid; e.a_pcs = m_pcs; e.a_rw = m_rw; e.a_mw = m_mw;
      e.a_cnt   = 8'(m_cnt_a);
      e.b_valid = live;
      e.b_pcs   = ok && s.pcs;
      e.b_rw    = ok && s.rw && !s.nw;
      e.b_mw    = ok && s.mw;
      e.b_cnt   = 2'(m_cnt_b);
      exp_q.push_back(e);

      if (!s.rst_n) begin
         model_reset();
      end else begin
         if (ok) begin
            if (s.fw[1]) m_bank[idx][3:2] = s.alu[3:2];
            if (s.fw[0]) m_bank[idx][1:0] = s.alu[1:0];
         end
         if (live && !ce) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
         end
         if (s.en) begin
            m_valid = s.valid && !s.flush;
            m_pcs   = ok && s.pcs;
            m_rw    = ok && s.rw && !s.nw;
            m_mw    = ok && s.mw;
         end
      end
   endtask

   // monitor: compares both instances against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_cond_ex", 32'(a_cond_ex), 32'(e.cond_ex));
            check("a_flags",   32'(a_flags),   32'(e.flags));
            check("a_valid",   32'(a_valid),   32'(e.a_valid));
            check("a_pcsrc",   32'(a_pcs),     32'(e.a_pcs));
            check("a_reg_w",   32'(a_rw),      32'(e.a_rw));
            check("a_mem_w",   32'(a_mw),      32'(e.a_mw));
            check("a_squash",  32'(a_cnt),     32'(e.a_cnt));
            check("b_cond_ex", 32'(b_cond_ex), 32'(e.cond_ex));
            check("b_flags",   32'(b_flags),   32'(e.flags));
            check("b_valid",   32'(b_valid),   32'(e.b_valid));
            check("b_pcsrc",   32'(b_pcs),     32'(e.b_pcs));
            check("b_reg_w",   32'(b_rw),      32'(e.b_rw));
            check("b_mem_w",   32'(b_mw),      32'(e.b_mw));
            check("b_squash",  32'(b_cnt),     32'(e.b_cnt));
         end
      end
   end

   initial begin
      stim_t s;
      int    waited;

      rst_n = 1'b0; en = 1'b0; flush = 1'b0; valid_i = 1'b0;
      cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
      pcs_i = 1'b0; reg_w_i = 1'b0; mem_w_i = 1'b0; no_write_i = 1'b0;
      ctx_sel = '0;
      model_reset();
      repeat (2) @(posedge clk);

      // reset state with EQ on Z=0
      s = idle(); s.cond = 4'h0; drive(s);

      // ctx0 SUBS sets Z, then EQ passes and writes a register
      s = idle(); s.valid = 1'b1; s.alu = 4'b0100; s.fw = 2'b11; drive(s);
      s = idle(); s.valid = 1'b1; s.cond = 4'h0; s.rw = 1'b1; drive(s);
      s = idle(); drive(s);

      // N=1,V=0: GE fails and counts, LT passes the store
      s = idle(); s.valid = 1'b1; s.alu = 4'b1000; s.fw = 2'b11; drive(s);
      s = idle(); s.valid = 1'b1; s.cond = 4'hA; s.mw = 1'b1; drive(s);
      s = idle(); s.valid = 1'b1; s.cond = 4'hB; s.mw = 1'b1; drive(s);
      s = idle(); drive(s);

      // partial write of N,Z only, then bank switching and select fallback
      s = idle(); s.valid = 1'b1; s.alu = 4'b1111; s.fw = 2'b11; drive(s);
      s = idle(); s.valid = 1'b1; s.alu = 4'b0000; s.fw = 2'b10; drive(s);
      s = idle(); s.ctx = 2'd1; drive(s);
      s = idle(); s.ctx = 2'd0; drive(s);
      s = idle(); s.ctx = 2'd3; drive(s);
      s = idle(); s.valid = 1'b1; s.ctx = 2'd3; s.alu = 4'b0110; s.fw = 2'b01; drive(s);
      s = idle(); s.ctx = 2'd0; drive(s);

      // flush beats valid; then a 3-cycle stall with writes offered
      s = idle(); s.valid = 1'b1; s.pcs = 1'b1; s.rw = 1'b1; drive(s);
      s = idle(); s.valid = 1'b1; s.flush = 1'b1; s.alu = 4'hF; s.fw = 2'b11; s.pcs = 1'b1; drive(s);
      s = idle(); s.valid = 1'b1; s.pcs = 1'b1; s.mw = 1'b1; drive(s);
      repeat (3) begin
         s = idle(); s.en = 1'b0; s.valid = 1'b1; s.alu = 4'hF; s.fw = 2'b11; s.flush = 1'b1; drive(s);
      end
      s = idle(); s.en = 1'b0; s.valid = 1'b1; s.cond = 4'hF; drive(s);
      s = idle(); drive(s);

      // five NV instructions saturate the 2-bit counter
      repeat (5) begin
         s = idle(); s.valid = 1'b1; s.cond = 4'hF; s.rw = 1'b1; drive(s);
      end
      s = idle(); s.valid = 1'b1; s.nw = 1'b1; s.rw = 1'b1; drive(s);

      // reset while stalled and flushing
      s = idle(); s.rst_n = 1'b0; s.en = 1'b0; s.flush = 1'b1; s.valid = 1'b1; drive(s);
      s = idle(); drive(s);

      // random traffic: a long reset-free stretch to saturate the 8-bit
      // counter, then a stretch with occasional resets
      for (int n = 0; n < 2800; n++) begin
         s.rst_n = (n < 1300) ? 1'b1 : ($urandom_range(0, 149) != 0);
         s.en    = ($urandom_range(0, 7) != 0);
         s.flush = ($urandom_range(0, 7) == 0);
         s.valid = ($urandom_range(0, 3) != 0);
         s.cond  = 4'($urandom_range(0, 15));
         s.alu   = 4'($urandom_range(0, 15));
         s.fw    = 2'($urandom_range(0, 3));
         s.pcs   = 1'($urandom_range(0, 1));
         s.rw    = 1'($urandom_range(0, 1));
         s.mw    = 1'($urandom_range(0, 1));
         s.nw    = ($urandom_range(0, 3) == 0);
         s.ctx   = 2'($urandom_range(0, 3));
         drive(s);
      end

      // drain the scoreboard within a bounded number of cycles
      waited = 0;
      while (exp_q.size() != 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
